comparator3_reg: RTL and testbench

Registered 3-bit unsigned magnitude comparator. Compares operand A = {a2,a1,a0} against operand B = {b2,b1,b0} and drives three mutually exclusive result flags: Equal, A_more, B_more. Flags are registered on the single system clock and consumed by downstream control logic as a one-hot compare status.

---
 rtl/comparator3_reg_if.sv | 33 +++
 rtl/comparator3_reg.sv | 66 ++++++
 tb/tb_comparator3_reg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/comparator3_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : comparator3_reg_if
// Description : Operand and result-flag bundle for the registered 3-bit
//               magnitude comparator. The master drives both operands and
//               observes the flags; the slave (the comparator) does the reverse.
// Revision    : 1.0 - initial release
// ============================================================================
interface comparator3_reg_if;
    // Operand A, bit 0 is the LSB
    logic a0;
    logic a1;
    logic a2;
    // Operand B, bit 0 is the LSB
    logic b0;
    logic b1;
    logic b2;
    // One-hot compare status; all zero means no result yet
    logic Equal;
    logic A_more;
    logic B_more;

    modport master (
        output a0, a1, a2, b0, b1, b2,
        input  Equal, A_more, B_more
    );

    modport slave (
        input  a0, a1, a2, b0, b1, b2,
        output Equal, A_more, B_more
    );
endinterface
`default_nettype wire

// File: rtl/comparator3_reg.sv
`default_nettype none
// ============================================================================
// Module      : comparator3_reg
// Description : Registered 3-bit unsigned magnitude comparator. Compares the
//               two operands MSB-first every cycle and registers a one-hot
//               Equal / A_more / B_more status with one clock of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator3_reg (
    input  wire logic         clk,
    input  wire logic         rst,
    comparator3_reg_if.slave  bus
);

    logic [2:0] w_a;
    logic [2:0] w_b;
    logic       w_equal;
    logic       w_a_more;
    logic       w_b_more;

    logic       r_equal;
    logic       r_a_more;
    logic       r_b_more;

    assign w_a = {bus.a2, bus.a1, bus.a0};
    assign w_b = {bus.b2, bus.b1, bus.b0};

    // MSB-first priority compare: the highest differing bit decides the winner
    always_comb begin
        w_equal  = 1'b0;
        w_a_more = 1'b0;
        w_b_more = 1'b0;
        if (w_a[2] != w_b[2]) begin
            w_a_more = w_a[2];
            w_b_more = w_b[2];
        end else if (w_a[1] != w_b[1]) begin
            w_a_more = w_a[1];
            w_b_more = w_b[1];
        end else if (w_a[0] != w_b[0]) begin
            w_a_more = w_a[0];
            w_b_more = w_b[0];
        end else begin
            w_equal  = 1'b1;
        end
    end

    // Register the compare result; reset clears all flags to "no result yet"
    always_ff @(posedge clk) begin
        if (rst) begin
            r_equal  <= 1'b0;
            r_a_more <= 1'b0;
            r_b_more <= 1'b0;
        end else begin
            r_equal  <= w_equal;
            r_a_more <= w_a_more;
            r_b_more <= w_b_more;
        end
    end

    // Flags come straight from flops so downstream logic sees no glitches
    assign bus.Equal  = r_equal;
    assign bus.A_more = r_a_more;
    assign bus.B_more = r_b_more;

endmodule
`default_nettype wire

// File: tb/tb_comparator3_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator3_reg
// Description : Self-checking bench for comparator3_reg. Expected flags come
//               from an integer-compare model, queued at drive time and
//               popped after the capturing clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator3_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    comparator3_reg_if bus ();

    comparator3_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {Equal, A_more, B_more}, one entry per driven cycle
    logic [2:0] exp_q[$];

    function automatic logic [2:0] model(input logic [2:0] a, input logic [2:0] b, input logic r);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        if (r) return 3'b000;
        return {ia == ib, ia > ib, ia < ib};
    endfunction

    function automatic logic [2:0] flags();
        return {bus.Equal, bus.A_more, bus.B_more};
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expected result
    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic r);
        @(negedge clk);
        rst    = r;
        bus.a2 = a[2];
        bus.a1 = a[1];
        bus.a0 = a[0];
        bus.b2 = b[2];
        bus.b1 = b[1];
        bus.b0 = b[0];
        exp_q.push_back(model(a, b, r));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        logic [2:0] exp;
        for (int i = 0; i < 2; i++) begin
            drive(3'(5 + i), 3'(2 - i), 1'b1);
            tick();
            got = flags();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || got !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, got, exp);
            end
        end
        drive(3'd0, 3'd0, 1'b0);
        tick();
        got = flags();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_b_greater();
        logic [2:0] got;
        logic [2:0] exp;
        logic [2:0] prev;
        prev = flags();
        drive(3'd3, 3'd5, 1'b0);
        #1;
        got = flags();
        checks++;
        if (got !== prev) begin
            errors++;
            $display("FAIL b_greater_hold: got %b expected %b", got, prev);
        end
        tick();
        got = flags();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== 3'b001) begin
            errors++;
            $display("FAIL b_greater: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_a_greater();
        logic [2:0] got;
        logic [2:0] exp;
        drive(3'd3, 3'd2, 1'b0);
        tick();
        got = flags();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got !== 3'b010) begin
            errors++;
            $display("FAIL a_greater: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_msb_extremes();
        logic [2:0] ta[3];
        logic [2:0] tb[3];
        logic [2:0] got;
        logic [2:0] exp;
        ta = '{3'd4, 3'd7, 3'd0};
        tb = '{3'd3, 3'd7, 3'd7};
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], 1'b0);
            tick();
            got = flags();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL msb_extreme A=%0d B=%0d: got %b expected %b", ta[i], tb[i], got, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0] got;
        logic [2:0] exp;
        logic       r_seq[3];
        r_seq = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(3'd6, 3'd1, r_seq[i]);
            tick();
            got = flags();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_midstream[%0d] rst=%0b: got %b expected %b", i, r_seq[i], got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got;
        logic [2:0] exp;
        for (int i = 0; i < 64; i++) begin
            drive(3'(i >> 3), 3'(i & 7), 1'b0);
            tick();
            got = flags();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sweep A=%0d B=%0d: got %b expected %b", i >> 3, i & 7, got, exp);
            end
            checks++;
            if ($countones(got) != 1) begin
                errors++;
                $display("FAIL onehot A=%0d B=%0d: got %b expected one-hot", i >> 3, i & 7, got);
            end
        end
    endtask

    // Watchdog so the run always ends even if the clock stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.a0 = 1'b0;
        bus.a1 = 1'b0;
        bus.a2 = 1'b0;
        bus.b0 = 1'b0;
        bus.b1 = 1'b0;
        bus.b2 = 1'b0;
        test_reset();
        test_b_greater();
        test_a_greater();
        test_msb_extremes();
        test_reset_midstream();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
